// File: rtl/ir_encode_issue_if.sv
// ir_encode_issue_if -- request and issue handshakes of the IR encoder front end.
//   in_*      : field-level instruction request (valid/ready, producer -> encoder)
//   ir_*      : packed 32-bit IR word (valid/ready, encoder -> executor)
//   slave     : encoder view (consumes requests, drives IR words)
//   master    : environment view (drives requests, consumes IR words)
interface ir_encode_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rdst;
  logic [4:0]  in_rsrc1;
  logic        in_imm_mode;
  logic [4:0]  in_rsrc2;
  logic [15:0] in_imm;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;

  modport slave (
    input  in_valid, in_op, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_imm, ir_ready,
    output in_ready, ir_out, ir_valid
  );

  modport master (
    output in_valid, in_op, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_imm, ir_ready,
    input  in_ready, ir_out, ir_valid
  );
endinterface

// File: rtl/ir_encode_issue.sv
// ir_encode_issue -- packs instruction requests into 32-bit IR words, canonicalises
// unused fields, drops illegal opcodes and issues words through a DEPTH-entry FIFO.
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   flush        : clears the FIFO; counters keep their values
//   bus          : request handshake in, IR word handshake out (ir_encode_issue_if)
//   illegal_op   : one-cycle pulse the cycle after an illegal request is accepted
//   illegal_cnt  : saturating count of rejected requests
//   issue_cnt    : wrapping count of words consumed by the executor
//   fifo_level   : current FIFO occupancy
module ir_encode_issue #(
  parameter int DEPTH  = 4,
  parameter int MAX_OP = 11,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  ir_encode_issue_if.slave        bus,
  output logic                    illegal_op,
  output logic [7:0]              illegal_cnt,
  output logic [CNT_W-1:0]        issue_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level
);
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [4:0] MAX_OP_L = 5'(MAX_OP);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rdst;
    logic [4:0]  rsrc1;
    logic        imm_mode;
    logic [4:0]  rsrc2;
    logic [15:0] imm;
  } req_t;

  // IR layout: op[31:27] rdst[26:22] rsrc1[21:17] imm_mode[16] then imm or {rsrc2,11'b0}.
  // movsgpr keeps only op/rdst; mov has no rsrc1 operand.
  function automatic logic [31:0] encode(input req_t r);
    logic [31:0] w;
    w = {r.op, r.rdst, r.rsrc1, r.imm_mode, (r.imm_mode ? r.imm : {r.rsrc2, 11'd0})};
    if (r.op == 5'd0)      w = {r.op, r.rdst, 22'd0};
    else if (r.op == 5'd1) w[21:17] = 5'd0;
    return w;
  endfunction

  req_t                   req;
  logic [DEPTH-1:0][31:0] mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic                   full, empty, accept, legal, push, pop, rej;

  assign req = '{op: bus.in_op, rdst: bus.in_rdst, rsrc1: bus.in_rsrc1,
                 imm_mode: bus.in_imm_mode, rsrc2: bus.in_rsrc2, imm: bus.in_imm};

  assign full  = (fifo_level == FULL_LVL);
  assign empty = (fifo_level == '0);

  // in_ready comes from occupancy only: a full FIFO refuses even while popping.
  assign bus.in_ready = !full;
  assign bus.ir_valid = !empty;
  assign bus.ir_out   = empty ? 32'h0 : mem[rd_ptr];

  assign accept = bus.in_valid & !full;
  assign legal  = (req.op <= MAX_OP_L);
  // flush drops a same-cycle push and freezes both counters.
  assign push   = accept & legal & !flush;
  assign rej    = accept & !legal & !flush;
  assign pop    = !empty & bus.ir_ready & !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= encode(req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      illegal_op  <= 1'b0;
      illegal_cnt <= '0;
      issue_cnt   <= '0;
    end else begin
      illegal_op <= rej;
      if (rej && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
      if (pop) issue_cnt <= issue_cnt + CNT_W'(1);
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
          2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
          default: fifo_level <= fifo_level;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ir_encode_issue.sv
module tb_ir_encode_issue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        illegal_op;
  logic [7:0]  illegal_cnt;
  logic [15:0] issue_cnt;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;

  ir_encode_issue_if bus();

  ir_encode_issue #(.DEPTH(4), .MAX_OP(11), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .illegal_op(illegal_op), .illegal_cnt(illegal_cnt),
    .issue_cnt(issue_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every consumed word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.ir_valid && bus.ir_ready && !flush) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word: got %h want none", bus.ir_out);
      end else begin
        exp_w = exp_q.pop_front();
        check("issued_word", bus.ir_out, exp_w);
      end
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic im, input logic [4:0] rs2, input logic [15:0] imm,
                      input logic [31:0] exp);
    logic acc;
    acc = 1'b0;
    bus.in_op = op; bus.in_rdst = rd; bus.in_rsrc1 = rs1;
    bus.in_imm_mode = im; bus.in_rsrc2 = rs2; bus.in_imm = imm;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = bus.in_ready;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else if (op <= 5'd11) begin
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !bus.ir_valid) break;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    check("drain_valid", {31'd0, bus.ir_valid}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},   {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_ir_valid"},   {31'd0, bus.ir_valid}, 32'd0);
    check({tag, "_ir_out"},     bus.ir_out, 32'd0);
    check({tag, "_illegal_op"}, {31'd0, illegal_op}, 32'd0);
    check({tag, "_illegal_cnt"}, {24'd0, illegal_cnt}, 32'd0);
    check({tag, "_issue_cnt"},  {16'd0, issue_cnt}, 32'd0);
    check({tag, "_level"},      {29'd0, fifo_level}, 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.ir_ready = 1'b0;
    bus.in_op = '0; bus.in_rdst = '0; bus.in_rsrc1 = '0;
    bus.in_imm_mode = 1'b0; bus.in_rsrc2 = '0; bus.in_imm = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // add imm, one-cycle latency
    @(posedge clk); #1;
    bus.ir_ready = 1'b1;
    send(5'd2, 5'd3, 5'd1, 1'b1, 5'd0, 16'h00FF, 32'h10C300FF);
    @(negedge clk);
    check("add_latency_valid", {31'd0, bus.ir_valid}, 32'd1);
    check("add_latency_word", bus.ir_out, 32'h10C300FF);
    wait_drain();
    check("issue_cnt_1", {16'd0, issue_cnt}, 32'd1);

    // Register mode with stray imm, mov, movsgpr canonicalisation
    send(5'd3, 5'd5, 5'd2, 1'b0, 5'd7, 16'hFFFF, 32'h19443800);
    send(5'd1, 5'd2, 5'd31, 1'b0, 5'd6, 16'h0000, 32'h08803000);
    send(5'd0, 5'd4, 5'd9, 1'b1, 5'd0, 16'hABCD, 32'h01000000);
    wait_drain();
    check("issue_cnt_4", {16'd0, issue_cnt}, 32'd4);

    // Illegal op
    send(5'b10000, 5'd1, 5'd1, 1'b0, 5'd1, 16'h0, 32'h0);
    @(negedge clk);
    check("illegal_pulse", {31'd0, illegal_op}, 32'd1);
    check("illegal_cnt_1", {24'd0, illegal_cnt}, 32'd1);
    check("illegal_level", {29'd0, fifo_level}, 32'd0);
    check("illegal_no_valid", {31'd0, bus.ir_valid}, 32'd0);
    @(negedge clk);
    check("illegal_pulse_end", {31'd0, illegal_op}, 32'd0);
    @(posedge clk); #1;
    bus.in_op = 5'd31; bus.in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("illegal_cnt_sat", {24'd0, illegal_cnt}, 32'd255);
    check("illegal_flood_level", {29'd0, fifo_level}, 32'd0);

    // Backpressure
    @(posedge clk); #1;
    bus.ir_ready = 1'b0;
    send(5'd2, 5'd1, 5'd2, 1'b1, 5'd0, 16'h1234, 32'h10451234);
    send(5'd3, 5'd2, 5'd3, 1'b0, 5'd4, 16'h0000, 32'h18862000);
    send(5'd11, 5'd31, 5'd31, 1'b1, 5'd0, 16'hBEEF, 32'h5FFFBEEF);
    send(5'd1, 5'd7, 5'd5, 1'b1, 5'd0, 16'h0042, 32'h09C10042);
    @(negedge clk);
    check("full_level", {29'd0, fifo_level}, 32'd4);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.in_op = 5'd4; bus.in_rdst = 5'd0; bus.in_rsrc1 = 5'd0;
    bus.in_imm_mode = 1'b0; bus.in_rsrc2 = 5'd31; bus.in_imm = 16'h0;
    bus.in_valid = 1'b1;
    exp_q.push_back(32'h2000F800);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("stall_valid", {31'd0, bus.ir_valid}, 32'd1);
      check("stall_word", bus.ir_out, 32'h10451234);
    end
    @(posedge clk); #1;
    bus.ir_ready = 1'b1;
    @(negedge clk);
    check("full_pop_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_pop_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("after_pop_level", {29'd0, fifo_level}, 32'd3);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_drain();
    check("issue_cnt_9", {16'd0, issue_cnt}, 32'd9);

    // Flush with a simultaneous push
    bus.ir_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(5'd2, 5'd1, 5'd1, 1'b1, 5'd0, 16'h0001, 32'h10430001);
    bus.in_op = 5'd3; bus.in_rdst = 5'd9; bus.in_rsrc1 = 5'd9;
    bus.in_imm_mode = 1'b1; bus.in_imm = 16'h5555;
    bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_level", {29'd0, fifo_level}, 32'd0);
    check("flush_valid", {31'd0, bus.ir_valid}, 32'd0);
    check("flush_word", bus.ir_out, 32'd0);
    check("flush_issue_cnt", {16'd0, issue_cnt}, 32'd9);
    check("flush_illegal_cnt", {24'd0, illegal_cnt}, 32'd255);

    // Reset mid-operation with an illegal request in the same cycle
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++)
      send(5'd2, 5'd1, 5'd1, 1'b1, 5'd0, 16'h0001, 32'h10430001);
    bus.in_op = 5'd20; bus.in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals("midrst");

    // Normal operation resumes
    @(posedge clk); #1;
    bus.ir_ready = 1'b1;
    send(5'd2, 5'd3, 5'd1, 1'b1, 5'd0, 16'h00FF, 32'h10C300FF);
    wait_drain();
    check("post_rst_issue_cnt", {16'd0, issue_cnt}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ir_encode_issue.md
Name: ir_encode_issue

Overview:
- Front end of the datapath. Packs field-level instruction requests into the 32-bit IR format and buffers them in a small FIFO.
- Issues IR words to the GPR execution unit over a valid/ready handshake.
- It is the encoder counterpart of the IR decoder/executor.
- It canonicalises unused fields, rejects illegal opcodes, and counts issued and rejected instructions.

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2)
- MAX_OP, 11, highest legal opcode (5'b01011, rnot)
- CNT_W, 16, width of the issue counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous FIFO clear; counters are kept
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  5  opcode
- in_rdst  in  5  destination register
- in_rsrc1  in  5  source register 1
- in_imm_mode  in  1  1 = immediate mode
- in_rsrc2  in  5  source register 2 (register mode)
- in_imm  in  16  immediate operand (immediate mode)
- ir_out  out  32  head IR word
- ir_valid  out  1  ir_out holds a valid word
- ir_ready  in  1  executor consumes on ir_valid & ir_ready
- illegal_op  out  1  one-cycle pulse for a rejected request
- illegal_cnt  out  8  saturating count of rejected requests
- issue_cnt  out  CNT_W  wrapping count of words consumed by the executor
- fifo_level  out  clog2(DEPTH)+1  current occupancy

Behaviour:

IR format (fixed):
- [31:27] op, [26:22] rdst, [21:17] rsrc1, [16] imm_mode.
- imm_mode=1: [15:0] = imm.
- imm_mode=0: [15:11] = rsrc2, [10:0] = 0.

Canonicalisation, applied before writing to the FIFO:
- op=movsgpr(0): only op and rdst are kept; all other bits are 0.
- op=mov(1): rsrc1 field forced to 0.
- All other legal ops: packed as given.

Illegal op (in_op > MAX_OP):
- The handshake still completes; in_ready is unaffected.
- Nothing is written to the FIFO.
- illegal_op is high for exactly the cycle after acceptance.
- illegal_cnt increments and saturates at 255.

Handshakes:
- in_ready = !full. It is a registered-state function and never depends on ir_ready, so a full FIFO does not accept even while popping.
- Push at edge N: the word is visible with ir_valid=1 from cycle N+1. There is no combinational bypass; minimum latency is 1 cycle.
- ir_valid = !empty. ir_out = head entry while valid, 32'h0 when empty.
- ir_out and ir_valid must stay stable while ir_valid & !ir_ready.

FIFO and counters:
- Simultaneous push and pop (not full, not empty): level unchanged, order preserved.
- Pointers wrap modulo DEPTH.
- issue_cnt increments on each pop and wraps from 2^CNT_W-1 to 0.

flush:
- Pointers and level go to 0 and ir_valid goes to 0 next cycle.
- A push in the same cycle is dropped.
- Counters are held.
- An illegal_op pulse already due still fires.

rst:
- Has priority over everything.
- Values after reset: in_ready=1, ir_valid=0, ir_out=0, illegal_op=0, illegal_cnt=0, issue_cnt=0, fifo_level=0.
- Reset mid-transfer discards all buffered words and any pending illegal pulse.

Test Plan:
- add imm: op=2, rdst=3, rsrc1=1, imm_mode=1, imm=0x00FF, ir_ready=1 -> next cycle ir_valid=1, ir_out=0x10C300FF; issue_cnt=1 after pop.
- sub reg with stray imm: op=3, rdst=5, rsrc1=2, rsrc2=7, imm_mode=0, imm=0xFFFF -> ir_out=0x19443800 (bits [10:0] zero). Then mov: op=1, rdst=2, rsrc1=31, rsrc2=6, imm_mode=0 -> ir_out=0x08803000.
- movsgpr canonicalisation: op=0, rdst=4, rsrc1=9, imm_mode=1, imm=0xABCD -> ir_out=0x01000000.
- Illegal: op=5'b10000 -> accepted, illegal_op pulse of 1 cycle, illegal_cnt=1, fifo_level stays 0, ir_valid stays 0. Send 300 illegal requests -> illegal_cnt=255.
- Backpressure: ir_ready=0, push 4 distinct words -> fifo_level=4, in_ready=0, 5th request held. Raise ir_ready -> words drain in push order, the 5th is accepted after the first pop, and ir_out is stable while stalled.
- Reset/flush mid-operation: with 3 words queued, assert flush together with a push -> level 0, pushed word lost, issue_cnt unchanged. Repeat with rst -> all outputs at reset values next cycle.
